// File: rtl/spi_memory_arbiter.sv
// spi_memory_arbiter: shares one frame-buffer SRAM between SPI byte requests and capture writes.
// SPI requests always win; capture writes fill the remaining cycles.
module spi_memory_arbiter #(
  parameter int ADDR_WIDTH   = 24,
  parameter int READ_LATENCY = 1
) (
  input  logic                  main_clock,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] spi_addr,
  input  logic [7:0]            spi_write_data,
  input  logic                  spi_write_flag,
  input  logic                  spi_read_flag,
  output logic [7:0]            spi_read_data,
  input  logic [ADDR_WIDTH-1:0] cap_addr,
  input  logic [7:0]            cap_data,
  input  logic                  cap_valid,
  output logic                  cap_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [7:0]            mem_rdata,
  output logic                  spi_overrun
);
  typedef enum logic [2:0] {IDLE, SPI_WR, SPI_RD, RD_WAIT, CAP_WR} state_t;
  state_t state_q, state_d;
  logic wr_d_q, rd_d_q, wr_pend_q, wr_pend_d, rd_pend_q, rd_pend_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d, mem_addr_q, mem_addr_d;
  logic [7:0] wr_data_q, wr_data_d, mem_wdata_q, mem_wdata_d, rdata_q, rdata_d;
  logic mem_we_q, mem_we_d, mem_re_q, mem_re_d, overrun_q, overrun_d;
  logic [1:0] cnt_q, cnt_d;
  logic wr_rise, rd_rise;
  assign wr_rise = spi_write_flag & ~wr_d_q;
  assign rd_rise = spi_read_flag & ~rd_d_q;
  assign cap_ready = reset_n & (state_q == IDLE) & ~wr_pend_q & ~rd_pend_q & ~wr_rise & ~rd_rise;
  assign spi_read_data = rdata_q;
  assign mem_addr = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we = mem_we_q;
  assign mem_re = mem_re_q;
  assign spi_overrun = overrun_q;
  always_ff @(posedge main_clock or negedge reset_n)
    if (!reset_n) begin
      state_q     <= IDLE;
      wr_d_q      <= 1'b0;
      rd_d_q      <= 1'b0;
      wr_pend_q   <= 1'b0;
      rd_pend_q   <= 1'b0;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      wr_data_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      rdata_q     <= '0;
      overrun_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      wr_d_q      <= spi_write_flag;
      rd_d_q      <= spi_read_flag;
      wr_pend_q   <= wr_pend_d;
      rd_pend_q   <= rd_pend_d;
      wr_addr_q   <= wr_addr_d;
      rd_addr_q   <= rd_addr_d;
      wr_data_q   <= wr_data_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      rdata_q     <= rdata_d;
      overrun_q   <= overrun_d;
      cnt_q       <= cnt_d;
    end
  // A pending slot is released when its request is dispatched from IDLE, so a rise
  // landing on the dispatch edge queues a fresh request rather than counting as overrun.
  always_comb begin
    state_d     = state_q;
    wr_pend_d   = wr_pend_q;
    rd_pend_d   = rd_pend_q;
    wr_addr_d   = wr_addr_q;
    rd_addr_d   = rd_addr_q;
    wr_data_d   = wr_data_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    rdata_d     = rdata_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE:
        if (wr_pend_q) begin
          state_d     = SPI_WR;
          mem_we_d    = 1'b1;
          mem_addr_d  = wr_addr_q;
          mem_wdata_d = wr_data_q;
          wr_pend_d   = 1'b0;
        end else if (rd_pend_q) begin
          state_d    = SPI_RD;
          mem_re_d   = 1'b1;
          mem_addr_d = rd_addr_q;
          rd_pend_d  = 1'b0;
        end else if (cap_valid && cap_ready) begin
          state_d     = CAP_WR;
          mem_we_d    = 1'b1;
          mem_addr_d  = cap_addr;
          mem_wdata_d = cap_data;
        end
      SPI_RD: begin
        state_d = RD_WAIT;
        cnt_d   = 2'(READ_LATENCY - 1);
      end
      RD_WAIT:
        if (cnt_q == 2'd0) begin
          state_d = IDLE;
          rdata_d = mem_rdata;
        end else cnt_d = cnt_q - 2'd1;
      default: state_d = IDLE;
    endcase
    overrun_d = overrun_q | (wr_rise & wr_pend_d) | (rd_rise & rd_pend_d);
    if (wr_rise) begin
      wr_pend_d = 1'b1;
      wr_addr_d = spi_addr;
      wr_data_d = spi_write_data;
    end
    if (rd_rise) begin
      rd_pend_d = 1'b1;
      rd_addr_d = spi_addr;
    end
  end
endmodule
